// File: rtl/nkmm_dbus_fifo_port.sv
// Memory-mapped TX/RX FIFO responder on the nkmm CPU data bus, with one-cycle registered read data.
// Optional RX path enabled by defining NKMM_DBUS_FIFO_RX_EN.
module nkmm_dbus_fifo_port #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 16'hFF00,
    parameter int                    DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic       sel;
    logic [1:0] idx;
    logic       stat_wr;

    assign sel     = (addr_i[ADDR_WIDTH-1:2] == BASE[ADDR_WIDTH-1:2]);
    assign idx     = addr_i[1:0];
    assign stat_wr = sel & we_i & (idx == 2'd2);

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [DEPTH_LOG2:0]   tx_count_q, tx_count_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  tx_push_req, tx_push, tx_pop, tx_full;

    assign tx_full     = (tx_count_q == FULL_CNT);
    assign tx_valid_o  = (tx_count_q != '0);
    assign tx_data_o   = tx_mem_q[tx_rptr_q];
    assign tx_pop      = tx_valid_o & tx_ready_i;
    assign tx_push_req = sel & we_i & (idx == 2'd0);
    // A push into a full FIFO still lands if the stream frees a slot this cycle.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
        if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
        tx_ovf_d = (tx_ovf_q & ~(stat_wr & data_i[5])) | (tx_push_req & ~tx_push);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_WIDTH-1:0] rx_head;
    logic [DEPTH_LOG2:0]   rx_cnt;
    logic                  rx_ovf;

`ifdef NKMM_DBUS_FIFO_RX_EN
    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [DEPTH_LOG2:0]   rx_count_q, rx_count_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic                  rx_push, rx_pop;

    assign rx_ready_o = (rx_count_q != FULL_CNT);
    assign rx_push    = rx_valid_i & rx_ready_o;
    assign rx_pop     = sel & we_i & (idx == 2'd1) & (rx_count_q != '0);
    assign rx_head    = rx_mem_q[rx_rptr_q];
    assign rx_cnt     = rx_count_q;
    assign rx_ovf     = rx_ovf_q;

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
        if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
        rx_ovf_d = (rx_ovf_q & ~(stat_wr & data_i[4])) | (rx_valid_i & ~rx_ready_o);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            rx_ovf_q   <= 1'b0;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end
`else
    logic rx_unused;
    assign rx_unused  = ^{rx_data_i, rx_valid_i};
    assign rx_ready_o = 1'b0;
    assign rx_head    = '0;
    assign rx_cnt     = '0;
    assign rx_ovf     = 1'b0;
`endif

    // ---------------- read port ----------------
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [5:0]            status;

    assign status = {tx_ovf_q, rx_ovf, tx_full, ~tx_valid_o,
                     (rx_cnt == FULL_CNT), (rx_cnt == '0)};

    always_comb begin
        data_d = '0;
        if (sel) begin
            case (idx)
                2'd1:    data_d = (rx_cnt == '0) ? '0 : rx_head;
                2'd2:    data_d = DATA_WIDTH'(status);
                2'd3:    data_d = DATA_WIDTH'({rx_cnt, tx_count_q});
                default: data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data_o = data_q;
endmodule

// File: tb/tb_nkmm_dbus_fifo_port.sv
// Directed + random bench for nkmm_dbus_fifo_port against a queue-based model of the register map.
module tb_nkmm_dbus_fifo_port;
    localparam int          DW   = 16;
    localparam int          AW   = 16;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          DEP  = 8;
`ifdef NKMM_DBUS_FIFO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          we_i = 1'b0;
    logic [DW-1:0] data_o, tx_data_o;
    logic          tx_valid_o, tx_ready_i = 1'b0;
    logic [DW-1:0] rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;

    nkmm_dbus_fifo_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE(BASE), .DEPTH_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
        .data_o(data_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: plain queues and flags.
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    bit            tx_ovf, rx_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = '0;
        if ((a >> 2) == (BASE >> 2)) begin
            case (a & 16'h3)
                1: r = (rxq.size() != 0) ? rxq[0] : '0;
                2: r = DW'((tx_ovf ? 32 : 0) + (rx_ovf ? 16 : 0) + (txq.size() == DEP ? 8 : 0)
                       + (txq.size() == 0 ? 4 : 0) + (rxq.size() == DEP ? 2 : 0) + (rxq.size() == 0 ? 1 : 0));
                3: r = DW'(rxq.size() * 16 + txq.size());
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // One bus cycle: drive inputs, predict, clock, update model, compare all outputs.
    task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                        input logic txr, input logic [DW-1:0] rxd, input logic rxv);
        logic [DW-1:0] exp_rd;
        bit sel, tx_pop, tx_room, rx_room;
        int idx;
        addr_i = a; data_i = d; we_i = we; tx_ready_i = txr; rx_data_i = rxd; rx_valid_i = rxv;
        exp_rd = model_read(a);
        sel = ((a >> 2) == (BASE >> 2));
        idx = int'(a & 16'h3);
        @(posedge clk);
        #1;
        tx_pop  = (txq.size() != 0) && txr;
        tx_room = (txq.size() < DEP);
        rx_room = (rxq.size() < DEP);
        if (sel && we && idx == 2) begin
            if (d[5]) tx_ovf = 0;
            if (d[4]) rx_ovf = 0;
        end
        if (tx_pop) void'(txq.pop_front());
        if (sel && we && idx == 0) begin
            if (tx_room || tx_pop) txq.push_back(d);
            else tx_ovf = 1;
        end
        if (RX_EN) begin
            if (sel && we && idx == 1 && rxq.size() != 0) void'(rxq.pop_front());
            if (rxv && rx_room) rxq.push_back(rxd);
            if (rxv && !rx_room) rx_ovf = 1;
        end
        chk("data_o", data_o, exp_rd);
        chk("tx_valid_o", tx_valid_o, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data_o", tx_data_o, txq[0]);
        chk("rx_ready_o", rx_ready_o, RX_EN && rxq.size() < DEP);
    endtask

    task automatic idle(input logic txr);
        step(16'h0000, '0, 1'b0, txr, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, '0);
        chk("rst_tx_valid", tx_valid_o, 1'b0);
        chk("rst_rx_ready", rx_ready_o, RX_EN);
        #2 rst_n = 1'b1;

        // Some traffic, then asynchronous reset off-edge
        for (int i = 0; i < 3; i++) step(BASE, DW'(16'h40 + i), 1'b1, 1'b0, DW'(16'h70 + i), 1'b1);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        addr_i = BASE + 16'd3; we_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data_o", data_o, '0);
        chk("async_rst_tx_valid", tx_valid_o, 1'b0);
        chk("async_rst_rx_ready", rx_ready_o, RX_EN);
        txq.delete(); rxq.delete(); tx_ovf = 0; rx_ovf = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("status_after_rst", data_o, 16'h0005);

        // TX fill to full, then overflow
        for (int i = 0; i < 8; i++) step(BASE, DW'(16'h11 + i), 1'b1, 1'b0, '0, 1'b0);
        step(BASE, 16'h0099, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd3, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("level_full", data_o, 16'h0008);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("status_tx_ovf", data_o, 16'h0029);
        chk("tx_head_11", tx_data_o, 16'h0011);

        // Clear tx_ovf, then push into full FIFO while the stream pops
        step(BASE + 16'd2, 16'h0020, 1'b1, 1'b0, '0, 1'b0);
        step(BASE, 16'h0099, 1'b1, 1'b1, '0, 1'b0);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("status_push_pop_full", data_o, 16'h0009);
        step(BASE + 16'd3, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("level_push_pop_full", data_o, 16'h0008);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", tx_data_o, (i < 7) ? 32'h12 + i : 32'h99);
            idle(1'b1);
        end
        chk("drained", tx_valid_o, 1'b0);

        // RX stream in, read and pop
        step(16'h0000, '0, 1'b0, 1'b0, 16'h00A1, 1'b1);
        step(16'h0000, '0, 1'b0, 1'b0, 16'h00A2, 1'b1);
        step(BASE + 16'd1, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_read_a1", data_o, RX_EN ? 16'h00A1 : 16'h0000);
        step(BASE + 16'd1, 16'h1234, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd1, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_read_a2", data_o, RX_EN ? 16'h00A2 : 16'h0000);
        step(BASE + 16'd1, '0, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd1, '0, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_empty_status", data_o, 16'h0005);

        // RX overflow and W1C, then clear racing a new overflow
        for (int i = 0; i < 9; i++) step(16'h0000, '0, 1'b0, 1'b0, DW'($urandom), 1'b1);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_ovf_status", data_o, RX_EN ? 16'h0016 : 16'h0005);
        step(BASE + 16'd2, 16'h0010, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_ovf_cleared", data_o, RX_EN ? 16'h0006 : 16'h0005);
        step(BASE + 16'd2, 16'h0010, 1'b1, 1'b0, '0, 1'b1);
        step(BASE + 16'd2, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("rx_ovf_set_wins", data_o, RX_EN ? 16'h0016 : 16'h0005);

        // Address decode boundaries
        step(BASE + 16'd4, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("unsel_hi", data_o, '0);
        step(BASE - 16'd1, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("unsel_lo", data_o, '0);
        step(BASE + 16'd4, 16'h0055, 1'b1, 1'b0, '0, 1'b0);
        step(BASE - 16'd1, 16'h0066, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd5, 16'h0001, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 16'd3, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("unsel_level", data_o, RX_EN ? 16'h0080 : 16'h0000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            a = (r < 8) ? BASE + AW'(r % 4) : (r == 8) ? BASE + 16'd4 : BASE - 16'd1;
            step(a, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
